// File: rtl/sar_adc_pkg.sv
// Shared types and constants for the SAR ADC sampler.
package sar_adc_pkg;

    localparam int SAMPLE_CNT_W   = 16;
    localparam int N_BITS_DEFAULT = 10;

    typedef enum logic [1:0] {
        IDLE,
        CONVERT,
        RELEASE
    } sampler_state_t;

endpackage

// File: rtl/sar_adc_sampler_if.sv
// Signal bundle between the sampler (master) and its ADC plus downstream consumer (slave).
interface sar_adc_sampler_if #(
    parameter int N_BITS = sar_adc_pkg::N_BITS_DEFAULT
);
    import sar_adc_pkg::*;

    logic                    enable_digital;
    logic                    adc_hold_digital;
    logic                    adc_eoc_digital;
    logic [N_BITS-1:0]       adc_result_digital;
    logic [N_BITS-1:0]       sample_data_digital;
    logic                    sample_valid_digital;
    logic                    sample_ready_digital;
    logic                    timeout_digital;
    logic [SAMPLE_CNT_W-1:0] sample_count_digital;

    modport master (
        input  enable_digital,
        output adc_hold_digital,
        input  adc_eoc_digital,
        input  adc_result_digital,
        output sample_data_digital,
        output sample_valid_digital,
        input  sample_ready_digital,
        output timeout_digital,
        output sample_count_digital
    );

    modport slave (
        output enable_digital,
        input  adc_hold_digital,
        output adc_eoc_digital,
        output adc_result_digital,
        input  sample_data_digital,
        input  sample_valid_digital,
        output sample_ready_digital,
        input  timeout_digital,
        input  sample_count_digital
    );

endinterface

// File: rtl/sar_sample_buffer.sv
// One- or two-entry sample buffer; a pop and a push on the same edge apply pop first.
module sar_sample_buffer
    import sar_adc_pkg::*;
#(
    parameter int N_BITS = N_BITS_DEFAULT,
    parameter int DEPTH  = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [N_BITS-1:0] push_data,
    input  logic              pop,
    output logic              full,
    output logic              empty,
    output logic [N_BITS-1:0] head
);
    localparam logic [1:0] DEPTH_V = 2'(DEPTH);

    logic [1:0]        occ;
    logic [1:0]        occ_after_pop;
    logic [N_BITS-1:0] slot0;
    logic [N_BITS-1:0] slot1;
    logic              pop_ok;
    logic              push_ok;

    // The push sees the occupancy left after this edge's pop, so a full buffer still accepts.
    assign pop_ok        = pop & (occ != 2'd0);
    assign occ_after_pop = occ - {1'b0, pop_ok};
    assign push_ok       = push & (occ_after_pop < DEPTH_V);

    assign full  = (occ == DEPTH_V);
    assign empty = (occ == 2'd0);
    assign head  = slot0;

    always_ff @(posedge clk) begin
        if (reset) begin
            occ   <= 2'd0;
            slot0 <= '0;
            slot1 <= '0;
        end else begin
            occ <= occ_after_pop + {1'b0, push_ok};
            if (pop_ok) begin
                slot0 <= slot1;
            end
            if (push_ok) begin
                if (occ_after_pop == 2'd0) begin
                    slot0 <= push_data;
                end else begin
                    slot1 <= push_data;
                end
            end
        end
    end

endmodule

// File: rtl/sar_adc_sampler.sv
// SAR ADC initiator: paces conversions, captures results, delivers them over valid/ready.
// Define SAR_SAMPLER_FIFO_EN for a 2-entry output FIFO instead of a single output register.
module sar_adc_sampler
    import sar_adc_pkg::*;
#(
    parameter int N_BITS        = N_BITS_DEFAULT,
    parameter int SAMPLE_PERIOD = 32,
    parameter int CONV_TIMEOUT  = 64
) (
    input logic               clk,
    input logic               reset,
    sar_adc_sampler_if.master bus
);
    localparam int PERIOD_W = $clog2(SAMPLE_PERIOD) + 1;
    localparam int TMO_W    = $clog2(CONV_TIMEOUT) + 1;
    localparam logic [PERIOD_W-1:0] PERIOD_RELOAD = PERIOD_W'(SAMPLE_PERIOD - 1);
    localparam logic [TMO_W-1:0]    TMO_LAST      = TMO_W'(CONV_TIMEOUT - 1);
`ifdef SAR_SAMPLER_FIFO_EN
    localparam int BUF_DEPTH = 2;
`else
    localparam int BUF_DEPTH = 1;
`endif

    sampler_state_t          state;
    logic                    hold;
    logic [PERIOD_W-1:0]     period_cnt;
    logic [TMO_W-1:0]        tmo_cnt;
    logic                    timeout_flag;
    logic [SAMPLE_CNT_W-1:0] sample_cnt;

    logic                    buf_push;
    logic                    buf_pop;
    logic                    buf_full;
    logic                    buf_empty;
    logic [N_BITS-1:0]       buf_head;
    logic                    has_space;
    logic                    start;

    assign buf_pop  = bus.sample_ready_digital & ~buf_empty;
    assign buf_push = (state == CONVERT) & bus.adc_eoc_digital;

`ifdef SAR_SAMPLER_FIFO_EN
    assign has_space = ~buf_full;
`else
    // A full single register counts as free when it is being popped on this edge.
    assign has_space = ~buf_full | bus.sample_ready_digital;
`endif

    assign start = bus.enable_digital & (period_cnt == '0) & has_space;

    sar_sample_buffer #(
        .N_BITS (N_BITS),
        .DEPTH  (BUF_DEPTH)
    ) u_buf (
        .clk       (clk),
        .reset     (reset),
        .push      (buf_push),
        .push_data (bus.adc_result_digital),
        .pop       (buf_pop),
        .full      (buf_full),
        .empty     (buf_empty),
        .head      (buf_head)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            hold         <= 1'b0;
            period_cnt   <= '0;
            tmo_cnt      <= '0;
            timeout_flag <= 1'b0;
        end else begin
            if (period_cnt != '0) begin
                period_cnt <= period_cnt - PERIOD_W'(1);
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        state      <= CONVERT;
                        hold       <= 1'b1;
                        period_cnt <= PERIOD_RELOAD;
                        tmo_cnt    <= '0;
                    end
                end
                CONVERT: begin
                    tmo_cnt <= tmo_cnt + TMO_W'(1);
                    // End-of-conversion wins over a timeout landing on the same cycle.
                    if (bus.adc_eoc_digital) begin
                        state <= RELEASE;
                        hold  <= 1'b0;
                    end else if (tmo_cnt == TMO_LAST) begin
                        state        <= RELEASE;
                        hold         <= 1'b0;
                        timeout_flag <= 1'b1;
                    end
                end
                RELEASE: begin
                    if (!bus.adc_eoc_digital) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    hold  <= 1'b0;
                end
            endcase
        end
    end

    // Written every cycle so the count always follows its own current value.
    always_ff @(posedge clk) begin
        if (reset) begin
            sample_cnt <= '0;
        end else begin
            sample_cnt <= sample_cnt + SAMPLE_CNT_W'(buf_pop);
        end
    end

    assign bus.adc_hold_digital     = hold;
    assign bus.sample_data_digital  = buf_head;
    assign bus.sample_valid_digital = ~buf_empty;
    assign bus.timeout_digital      = timeout_flag;
    assign bus.sample_count_digital = sample_cnt;

endmodule

// File: doc/sar_adc_sampler.md
# sar_adc_sampler

Digital initiator for the SAR ADC conversion interface. It paces conversions, drives the ADC hold/start line, captures the result when the ADC raises end-of-conversion, and delivers samples downstream over a valid/ready handshake. It sits between `sar_adc__N_BITS_10` (on the `sys_clk` domain) and the digital consumer, and it makes a hung converter visible through a conversion timeout.

## Interface
Parameters:
- `N_BITS`, default 10: ADC result width.
- `SAMPLE_PERIOD`, default 32: minimum cycles between successive hold rising edges. Must be at least 4.
- `CONV_TIMEOUT`, default 64: maximum cycles spent in CONVERT before the conversion is aborted.

Ports:
- `clk` in 1: the only clock. Connect to the ADC `sys_clk`.
- `reset` in 1: synchronous, active-high.
- `enable_digital` in 1: permits new conversions to start.
- `adc_hold_digital` out 1: drives the ADC `input_hold_digital`.
- `adc_eoc_digital` in 1: ADC `eoc`, a level signal.
- `adc_result_digital` in `N_BITS`: ADC `output_result_digital`.
- `sample_data_digital` out `N_BITS`: captured sample.
- `sample_valid_digital` out 1: sample available.
- `sample_ready_digital` in 1: consumer accepts the sample.
- `timeout_digital` out 1: sticky flag, set when a conversion is aborted.
- `sample_count_digital` out 16: count of delivered samples. Wraps from 0xFFFF to 0.

## Operation
FSM states are IDLE, CONVERT, RELEASE.
- IDLE, `hold`=0. Go to CONVERT when all three hold: `enable_digital`=1, the period counter is 0, and the buffer has space.
- CONVERT, `hold`=1.
  - If `adc_eoc_digital`=1, capture `adc_result_digital` into the buffer and go to RELEASE.
  - Otherwise, if the timeout counter reaches `CONV_TIMEOUT-1`, set `timeout_digital`, discard the conversion and go to RELEASE.
- RELEASE, `hold`=0. Stay until `adc_eoc_digital`=0, then go to IDLE. This guarantees the ADC sees `hold` low for at least 1 cycle.

Period counter:
- Loaded with `SAMPLE_PERIOD-1` on entry to CONVERT.
- Decrements each cycle while non-zero. It saturates at 0 and does not wrap.

Timeout counter:
- Cleared on entry to CONVERT.
- Increments only while in CONVERT.

Other rules:
- Dropping `enable_digital` mid-conversion does not abort the conversion. The in-flight sample completes and is delivered, and no new conversion starts.
- A handshake completes when `valid` and `ready` are both 1 on a rising clock edge. On each completed handshake, `sample_count_digital` increments.
- `adc_eoc_digital` seen in IDLE or RELEASE is ignored. It never captures data.
- Reset values:
  - state IDLE
  - `adc_hold_digital`=0
  - `sample_valid_digital`=0
  - `sample_data_digital`=0
  - `timeout_digital`=0
  - `sample_count_digital`=0
  - both counters 0
  - buffer empty
- Reset asserted mid-CONVERT drops `hold` on the next edge and discards the conversion.

## Timing
- `hold` rises 1 cycle after the IDLE start condition is sampled true.
- Capture latency: `sample_valid_digital` is 1 in the cycle after the edge that samples `eoc`=1 in CONVERT.
- `sample_data_digital` is stable while `valid`=1 and `ready`=0. `valid` never drops without a handshake, except on reset.
- Same-edge capture and pop with the buffer full:
  - The pop takes effect first.
  - The write then succeeds.
  - No data is lost, and `valid` stays 1.
- Timeout:
  - `hold` is high for exactly `CONV_TIMEOUT` cycles.
  - `timeout_digital` becomes 1 on the edge that leaves CONVERT.
  - `timeout_digital` clears only on `reset`.
- Minimum start-to-start spacing is max(`SAMPLE_PERIOD`, conversion cycles + 2).

## Configuration
`SAR_SAMPLER_FIFO_EN`:
- Defined: the output buffer is a 2-entry FIFO. A new conversion may start while 1 entry is occupied. Space means occupancy < 2.
- Undefined: the output buffer is a single register. A conversion starts only when the register is empty, or is being popped on the same edge. Space means `!valid | ready`.
- Handshake, timing and reset behaviour are otherwise identical in both builds.

## Structure
- Package `sar_adc_pkg` holds:
  - the state enum `sampler_state_t` (IDLE, CONVERT, RELEASE);
  - the `SAMPLE_CNT_W`=16 constant;
  - the default `N_BITS`.
- Sub-module `sar_sample_buffer`:
  - parameterized by `N_BITS` and depth 1 or 2;
  - exposes push/pop/full/empty;
  - implements the same-edge pop-then-push rule.
- The FSM, both counters and the timeout flag live in the top module.

## Test plan
- Basic conversion: `enable`=1 out of reset, with a model ADC that raises `eoc` 5 cycles after `hold` and returns 0x1A5, and `ready`=1. Required: `hold` high for 6 cycles; `sample_data`=0x1A5 with `valid` for 1 cycle; `sample_count`=1.
- Pacing: `SAMPLE_PERIOD`=32 with continuous operation. Required: `hold` rising edges exactly 32 cycles apart across 10 samples.
- Backpressure: `ready`=0 for 100 cycles.
  - With `SAR_SAMPLER_FIFO_EN` undefined: exactly 1 conversion is issued.
  - With `SAR_SAMPLER_FIFO_EN` defined: exactly 2 conversions are issued.
  - In both builds, raising `ready` then drains the samples in order with no loss.
- Timeout: the ADC never raises `eoc`, with `CONV_TIMEOUT`=64. Required:
  - `hold` high for 64 cycles, then low;
  - `timeout_digital`=1, no sample delivered;
  - the next conversion proceeds normally;
  - the flag persists until `reset`.
- Disruption: drop `enable` mid-CONVERT. Required: the sample is still delivered and no further `hold` is issued. Separately, assert `reset` mid-CONVERT. Required: `hold`=0 the next cycle and `valid` never rises.
- Wrap: preload to 0xFFFF via a forced count, then complete 1 handshake. Required: `sample_count_digital`=0x0000.
